// File: rtl/vfreq_pkg.sv
// Shared types and constants for the variable-frequency generator/meter pair.
// Counter width default is common to both sides of the loopback.
package vfreq_pkg;

    localparam int VFREQ_CNT_W = 16;

    typedef enum logic [1:0] {
        WAIT_FIRST = 2'd0,
        COUNT      = 2'd1,
        STALLED    = 2'd2
    } vfreq_state_t;

    // All-ones value of a counter of width w.
    function automatic longint unsigned cnt_max(input int w);
        return (longint'(1) << w) - longint'(1);
    endfunction

endpackage

// File: rtl/vfreq_sync_edge.sv
// Synchronizes an asynchronous pin and emits one-cycle rise/fall pulses.
// Latency: STAGES+1 clk edges from pin change to pulse consumption; no backpressure.
module vfreq_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;
    logic              level;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/vfreq_meter.sv
// Measures period and high time of an asynchronous square wave in clk cycles.
// Result registered one cycle after the detected rise; free-running, no backpressure.
module vfreq_meter
    import vfreq_pkg::*;
#(
    parameter int CNT_W       = VFREQ_CNT_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period_o,
    output logic [CNT_W-1:0] high_o,
    output logic             valid_o,
    output logic             stalled_o,
    output logic             locked_o
);

    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(cnt_max(CNT_W));
    localparam logic [CNT_W-1:0] CNT_STALL = CNT_MAX - CNT_W'(1);

    logic rise;
    logic fall;

    vfreq_sync_edge #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (sig_in),
        .rise  (rise),
        .fall  (fall)
    );

    vfreq_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hi_q, hi_d;
    logic [CNT_W-1:0] period_d, high_d;
    logic             valid_d, stalled_d, locked_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= WAIT_FIRST;
            cnt_q     <= '0;
            hi_q      <= '0;
            period_o  <= '0;
            high_o    <= '0;
            valid_o   <= 1'b0;
            stalled_o <= 1'b0;
            locked_o  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            period_o  <= period_d;
            high_o    <= high_d;
            valid_o   <= valid_d;
            stalled_o <= stalled_d;
            locked_o  <= locked_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        hi_d      = hi_q;
        period_d  = period_o;
        high_d    = high_o;
        valid_d   = 1'b0;
        stalled_d = stalled_o;
        locked_d  = locked_o;

        // Every rise restarts the interval so a stale high time never leaks forward.
        if (rise) begin
            cnt_d = CNT_W'(1);
            hi_d  = '0;
        end

        case (state_q)
            WAIT_FIRST: begin
                if (rise) state_d = COUNT;
            end
            COUNT: begin
                if (rise) begin
                    period_d = cnt_q;
                    high_d   = hi_q;
                    valid_d  = 1'b1;
                    locked_d = 1'b1;
                end else begin
                    if (fall) hi_d = cnt_q;
                    // Stall flags in the same edge the counter saturates.
                    if (cnt_q == CNT_STALL) begin
                        state_d   = STALLED;
                        stalled_d = 1'b1;
                        locked_d  = 1'b0;
                    end
                end
            end
            STALLED: begin
                if (rise) begin
                    state_d   = COUNT;
                    stalled_d = 1'b0;
                end
            end
            default: state_d = WAIT_FIRST;
        endcase
    end

endmodule

// File: tb/tb_vfreq_meter.sv
// Self-checking bench for vfreq_meter: 16-bit and 8-bit instances share one input,
// each compared every cycle against an event-timestamp reference model.
module tb_vfreq_meter;

    localparam int S = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sig_in = 1'b0;
    logic [15:0] p16, h16;
    logic        v16, st16, lk16;
    logic [7:0]  p8, h8;
    logic        v8, st8, lk8;

    always #5 clk = ~clk;

    vfreq_meter #(.CNT_W(16), .SYNC_STAGES(S)) dut16 (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_in),
        .period_o(p16), .high_o(h16), .valid_o(v16), .stalled_o(st16), .locked_o(lk16)
    );

    vfreq_meter #(.CNT_W(8), .SYNC_STAGES(S)) dut8 (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_in),
        .period_o(p8), .high_o(h8), .valid_o(v8), .stalled_o(st8), .locked_o(lk8)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: tracks timestamps of detected rises/falls, not counters.
    int m_period[2];
    int m_high[2];
    bit m_valid[2];
    bit m_stalled[2];
    bit m_locked[2];
    bit m_have[2];
    int m_last[2];
    int m_hi[2];
    int mmax[2] = '{65535, 255};
    bit hist[S+1];
    int ecyc = 0;

    always @(posedge clk) begin
        bit r, f;
        ecyc++;
        if (!rst_n) begin
            for (int k = 0; k <= S; k++) hist[k] = 1'b0;
            for (int d = 0; d < 2; d++) begin
                m_period[d] = 0; m_high[d] = 0; m_valid[d] = 0; m_stalled[d] = 0;
                m_locked[d] = 0; m_have[d] = 0; m_last[d] = 0; m_hi[d] = 0;
            end
        end else begin
            r = hist[S-1] && !hist[S];
            f = !hist[S-1] && hist[S];
            for (int k = S; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = sig_in;
            for (int d = 0; d < 2; d++) begin
                m_valid[d] = 0;
                if (r) begin
                    if (m_have[d] && !m_stalled[d]) begin
                        m_period[d] = ecyc - m_last[d];
                        m_high[d]   = m_hi[d];
                        m_valid[d]  = 1;
                        m_locked[d] = 1;
                    end
                    m_stalled[d] = 0;
                    m_have[d]    = 1;
                    m_last[d]    = ecyc;
                    m_hi[d]      = 0;
                end else if (m_have[d] && !m_stalled[d]) begin
                    if (f) m_hi[d] = ecyc - m_last[d];
                    if (ecyc - m_last[d] == mmax[d] - 1) begin
                        m_stalled[d] = 1;
                        m_locked[d]  = 0;
                    end
                end
            end
        end
    end

    // Per-cycle comparison plus bookkeeping for the directed sequences.
    int cyc = 0;
    int last_p16 = 0, last_h16 = 0, nval16 = 0, odd16 = 0;
    int last_p8 = 0, last_h8 = 0, nval8 = 0, last_vcyc8 = 0;
    int stall_cyc8 = -1;
    bit st8_d = 1'b0;
    bit first_after_rst = 1'b0;
    int first_p16 = 0;

    always @(negedge clk) begin
        cyc++;
        chk("period16", int'(p16), m_period[0]);
        chk("high16", int'(h16), m_high[0]);
        chk("valid16", int'(v16), int'(m_valid[0]));
        chk("stalled16", int'(st16), int'(m_stalled[0]));
        chk("locked16", int'(lk16), int'(m_locked[0]));
        chk("period8", int'(p8), m_period[1]);
        chk("high8", int'(h8), m_high[1]);
        chk("valid8", int'(v8), int'(m_valid[1]));
        chk("stalled8", int'(st8), int'(m_stalled[1]));
        chk("locked8", int'(lk8), int'(m_locked[1]));
        if (v16) begin
            last_p16 = int'(p16); last_h16 = int'(h16); nval16++;
            if (p16 != 16'd64) odd16++;
            if (first_after_rst) begin first_p16 = int'(p16); first_after_rst = 1'b0; end
        end
        if (v8) begin
            last_p8 = int'(p8); last_h8 = int'(h8); nval8++; last_vcyc8 = cyc;
        end
        if (st8 && !st8_d) stall_cyc8 = cyc;
        st8_d = st8;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    task automatic drive_wave(input int h, input int l, input int n);
        for (int k = 0; k < n; k++) begin
            sig_in = 1'b1;
            wait_cyc(h);
            sig_in = 1'b0;
            wait_cyc(l);
        end
    endtask

    typedef struct {
        int hi;
        int lo;
        int n;
        int exp_p;
        int exp_h;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int n0, nr;

        tbl[0] = '{10, 10, 8, 20, 10};
        tbl[1] = '{3, 3, 8, 6, 3};
        tbl[2] = '{32, 32, 5, 64, 32};
        tbl[3] = '{1, 1, 10, 2, 1};
        tbl[4] = '{3, 17, 5, 20, 3};
        tbl[5] = '{17, 3, 5, 20, 17};

        rst_n = 1'b0;
        sig_in = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_period16", int'(p16), 0);
        chk("rst_valid16", int'(v16), 0);
        chk("rst_locked16", int'(lk16), 0);
        chk("rst_stalled8", int'(st8), 0);
        @(posedge clk);
        #3 rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            if (i == 2) odd16 = 0;
            n0 = nval16;
            drive_wave(tbl[i].hi, tbl[i].lo, tbl[i].n);
            wait_cyc(5);
            chk($sformatf("row%0d_period", i), last_p16, tbl[i].exp_p);
            chk($sformatf("row%0d_high", i), last_h16, tbl[i].exp_h);
            chk($sformatf("row%0d_period8", i), last_p8, tbl[i].exp_p);
            chk($sformatf("row%0d_locked", i), int'(lk16), 1);
            chk($sformatf("row%0d_nvalid", i), int'((nval16 - n0) >= (tbl[i].n - 1)), 1);
            if (i == 2) chk("transitional_count", odd16, 1);
        end

        // Stall on the 8-bit instance: input held low for 300 cycles.
        drive_wave(10, 10, 3);
        stall_cyc8 = -1;
        wait_cyc(300);
        chk("stall_delay", stall_cyc8 - last_vcyc8, 254);
        chk("stall_flag8", int'(st8), 1);
        chk("stall_unlock8", int'(lk8), 0);
        chk("stall_hold_p8", int'(p8), 20);
        chk("stall_hold_h8", int'(h8), 10);
        chk("nostall16", int'(st16), 0);
        chk("lock16_kept", int'(lk16), 1);
        n0 = nval8;
        drive_wave(10, 10, 1);
        chk("stall_rise_novalid", nval8 - n0, 0);
        chk("stall_cleared8", int'(st8), 0);
        drive_wave(10, 10, 1);
        wait_cyc(5);
        chk("stall_recover_nvalid", nval8 - n0, 1);
        chk("stall_recover_p8", last_p8, 20);
        chk("stall_recover_lock8", int'(lk8), 1);

        // One-cycle reset during the low phase of a 20-cycle wave.
        nr = 0;
        fork
            drive_wave(10, 10, 6);
            begin
                wait_cyc(35);
                rst_n = 1'b0;
                @(posedge clk);
                @(negedge clk);
                chk("midrst_period16", int'(p16), 0);
                chk("midrst_high16", int'(h16), 0);
                chk("midrst_locked16", int'(lk16), 0);
                chk("midrst_valid16", int'(v16), 0);
                chk("midrst_period8", int'(p8), 0);
                rst_n = 1'b1;
                nr = nval16;
                first_after_rst = 1'b1;
            end
        join
        wait_cyc(5);
        chk("postrst_nvalid", nval16 - nr, 3);
        chk("postrst_first_period", first_p16, 20);
        chk("postrst_lock", int'(lk16), 1);

        // Randomized waveform, occasionally with gaps long enough to stall CNT_W=8.
        for (int k = 0; k < 40; k++) begin
            int h, l;
            h = $urandom_range(40, 1);
            l = ($urandom_range(9, 0) == 0) ? $urandom_range(400, 200) : $urandom_range(40, 1);
            drive_wave(h, l, 1);
        end
        wait_cyc(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
